alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Moore-style sequencer that drives the calculator datapath (register file, ALU, result display mux) for one operation per debounced Go press. It captures operands and opcode, writes the operands into the register file, reads them back, starts the ALU, and waits a per-opcode latency. It then writes the result back, selects it for display and raises Done. It sits between the debounce output and the register-file/ALU/LED-mux datapath, and supplies the state code shown on the status display.

## Interface
Parameters:
- MUL_LAT, 4: ALU cycles for multiply (op 100); legal range 1..16
- DIV_LAT, 8: ALU cycles for divide (op 101); legal range 1..16

Ports:
- clk50MHz  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  debounced Go level; rising edge starts an operation
- op  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 mul, 101 div, 11x pass-A; all except mul/div take 1 cycle
- in1, in2  in  4 each  operand values from switches
- op_q  out  3  latched opcode to ALU
- wd  out  4  register-file write data: in1_q in WR_A, in2_q in WR_B, else 0
- we  out  1  register-file write enable
- wa  out  2  write address: 0 in WR_A, 1 in WR_B, 2 in WB, else 0
- rea, reb  out  1 each  read enables for ports A (reg0) and B (reg1)
- s1  out  1  write-data mux: 0 = wd, 1 = ALU result
- s2  out  1  display mux: 1 = result register, 0 = operands
- alu_start  out  1  one-cycle ALU start pulse
- CS_out  out  4  current state code
- Done_out  out  1  operation-complete LED
- Err_out  out  1  divide-by-zero LED; constant 0 unless ALU_SEQ_DIVZ_EN is defined

## Operation
- Edge detect: go_q <= go; start = go & ~go_q. go_q resets to 1, so a Go held high through reset does not start an operation.
- Start is honoured only in IDLE, DONE and ERR. Starts in any other state are discarded, not queued.
- On an accepted start, latch in1_q, in2_q and op_q. Latched values are held until the next accepted start.
- States and CS_out codes:
  - IDLE=0
  - WR_A=1 (we, wa=0)
  - WR_B=2 (we, wa=1)
  - RD=3 (rea, reb)
  - EXEC=4 (rea, reb, alu_start)
  - WAIT=5 (rea, reb)
  - WB=6 (we, wa=2, s1)
  - DONE=7 (s2, Done_out)
  - ERR=8 (Err_out, Done_out)
- Transitions:
  - IDLE/DONE/ERR -> WR_A on start.
  - WR_A -> WR_B -> RD.
  - RD -> EXEC.
  - EXEC -> WB if latency L=1, else load a wait counter with L-2 and go to WAIT.
  - WAIT decrements the counter; at 0 -> WB.
  - WB -> DONE.
- L is MUL_LAT for op 100, DIV_LAT for op 101, and 1 otherwise.
- Unused state encodings 9..15 -> IDLE on the next edge, with all outputs 0.
- All outputs are decoded from the state register only; there is no combinational path from input to output except the tied-off Err_out.

## Timing
- Reset: state IDLE. All outputs 0, CS_out=0, counter 0, latches 0, go_q=1.
- A start sampled at edge N gives WR_A after N. Done_out goes high after edge N+L+5: 6 cycles for L=1, 9 for mul with the default, 13 for div with the default.
- alu_start is high for exactly 1 cycle. rea/reb stay high from RD through the last WAIT cycle, which is L+1 cycles.
- Done_out and s2 stay high in DONE until the next accepted start. They fall on the edge that enters WR_A.
- rst asserted in any state, including mid-WAIT: IDLE on that edge. The operation is abandoned and WB is never issued.
- Start and rst in the same cycle: rst wins.

## Configuration
- ALU_SEQ_DIVZ_EN defined:
  - In RD, if op_q=101 and in2_q=0, go to ERR instead of EXEC.
  - No alu_start and no WB occur.
  - Err_out=1 and Done_out=1 until the next accepted start or rst.
- Undefined: the ERR state does not exist, Err_out=0, and divide-by-zero runs the normal DIV_LAT sequence.

## Test plan
- Reset with go=1, release rst, hold go=1 for 20 cycles -> stays IDLE, CS_out=0, no we pulse.
- go rises with in1=5, in2=3, op=000 -> wd=5/wa=0, then wd=3/wa=1 on successive cycles; single alu_start; WB with wa=2, s1=1; Done_out high 6 cycles after the start edge.
- op=100, MUL_LAT=4 -> CS_out sequence 1,2,3,4,5,5,5,6,7; Done_out after 9 cycles; rea/reb high 5 cycles.
- A second go edge during WAIT -> ignored. A go edge in DONE -> WR_A next cycle with new operands latched and Done_out low.
- rst pulsed mid-WAIT of a div -> IDLE next edge, all outputs 0, no WB write observed.
- With ALU_SEQ_DIVZ_EN: op=101, in2=0 -> CS_out 1,2,3,8; Err_out=Done_out=1, no alu_start. Without the macro, the same stimulus completes in 13 cycles with Err_out=0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Moore sequencer for the calculator datapath: one operation per Go press.
// Optional macro ALU_SEQ_DIVZ_EN adds the divide-by-zero ERR state.

// state  | code | meaning
// IDLE   | 0    | waiting for Go
// WR_A   | 1    | write in1 to reg0
// WR_B   | 2    | write in2 to reg1
// RD     | 3    | read both operands
// EXEC   | 4    | pulse alu_start
// WAIT   | 5    | multi-cycle ALU latency
// WB     | 6    | write ALU result to reg2
// DONE   | 7    | show result, Done LED
// ERR    | 8    | divide by zero (ALU_SEQ_DIVZ_EN only)
module alu_seq_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] op,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  output logic [2:0] op_q,
  output logic [3:0] wd,
  output logic       we,
  output logic [1:0] wa,
  output logic       rea,
  output logic       reb,
  output logic       s1,
  output logic       s2,
  output logic       alu_start,
  output logic [3:0] CS_out,
  output logic       Done_out,
  output logic       Err_out
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WR_A = 4'd1,
    ST_WR_B = 4'd2,
    ST_RD   = 4'd3,
    ST_EXEC = 4'd4,
    ST_WAIT = 4'd5,
    ST_WB   = 4'd6,
`ifdef ALU_SEQ_DIVZ_EN
    ST_DONE = 4'd7,
    ST_ERR  = 4'd8
`else
    ST_DONE = 4'd7
`endif
  } state_t;

  localparam logic [4:0] MUL_L = 5'(MUL_LAT);
  localparam logic [4:0] DIV_L = 5'(DIV_LAT);

  state_t     state_q, state_d;
  logic       go_q;
  logic [3:0] in1_q, in2_q;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] lat;
  logic       start;
  logic       accept;

  assign start = go & ~go_q;

  always_comb begin
    accept = 1'b0;
    if (start) begin
      case (state_q)
        ST_IDLE, ST_DONE: accept = 1'b1;
`ifdef ALU_SEQ_DIVZ_EN
        ST_ERR:           accept = 1'b1;
`endif
        default:          accept = 1'b0;
      endcase
    end
  end

  always_comb begin
    lat = 5'd1;
    if (op_q == 3'b100)      lat = MUL_L;
    else if (op_q == 3'b101) lat = DIV_L;
  end

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state_q <= ST_IDLE;
      go_q    <= 1'b1;
      in1_q   <= 4'd0;
      in2_q   <= 4'd0;
      op_q    <= 3'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
      cnt_q   <= cnt_d;
      if (accept) begin
        in1_q <= in1;
        in2_q <= in2;
        op_q  <= op;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_WR_A;
      ST_WR_A: state_d = ST_WR_B;
      ST_WR_B: state_d = ST_RD;
      ST_RD: begin
        state_d = ST_EXEC;
`ifdef ALU_SEQ_DIVZ_EN
        if (op_q == 3'b101 && in2_q == 4'd0) state_d = ST_ERR;
`endif
      end
      ST_EXEC: begin
        if (lat == 5'd1) begin
          state_d = ST_WB;
        end else begin
          cnt_d   = 4'(lat - 5'd2);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_WB;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_WB:   state_d = ST_DONE;
      ST_DONE: if (accept) state_d = ST_WR_A;
`ifdef ALU_SEQ_DIVZ_EN
      ST_ERR:  if (accept) state_d = ST_WR_A;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state and latched operands.
  always_comb begin
    wd        = 4'd0;
    we        = 1'b0;
    wa        = 2'd0;
    rea       = 1'b0;
    reb       = 1'b0;
    s1        = 1'b0;
    s2        = 1'b0;
    alu_start = 1'b0;
    CS_out    = 4'd0;
    Done_out  = 1'b0;
`ifdef ALU_SEQ_DIVZ_EN
    Err_out   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: CS_out = 4'd0;
      ST_WR_A: begin
        CS_out = 4'd1;
        we     = 1'b1;
        wd     = in1_q;
      end
      ST_WR_B: begin
        CS_out = 4'd2;
        we     = 1'b1;
        wa     = 2'd1;
        wd     = in2_q;
      end
      ST_RD: begin
        CS_out = 4'd3;
        rea    = 1'b1;
        reb    = 1'b1;
      end
      ST_EXEC: begin
        CS_out    = 4'd4;
        rea       = 1'b1;
        reb       = 1'b1;
        alu_start = 1'b1;
      end
      ST_WAIT: begin
        CS_out = 4'd5;
        rea    = 1'b1;
        reb    = 1'b1;
      end
      ST_WB: begin
        CS_out = 4'd6;
        we     = 1'b1;
        wa     = 2'd2;
        s1     = 1'b1;
      end
      ST_DONE: begin
        CS_out   = 4'd7;
        s2       = 1'b1;
        Done_out = 1'b1;
      end
`ifdef ALU_SEQ_DIVZ_EN
      ST_ERR: begin
        CS_out   = 4'd8;
        Err_out  = 1'b1;
        Done_out = 1'b1;
      end
`endif
      default: CS_out = 4'd0;
    endcase
  end

`ifndef ALU_SEQ_DIVZ_EN
  assign Err_out = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with default latencies.
module tb_alu_seq_ctrl;

  logic       clk50MHz = 1'b0;
  logic       rst;
  logic       go;
  logic [2:0] op;
  logic [3:0] in1, in2;
  logic [2:0] op_q;
  logic [3:0] wd;
  logic       we;
  logic [1:0] wa;
  logic       rea, reb, s1, s2, alu_start;
  logic [3:0] CS_out;
  logic       Done_out, Err_out;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl #(.MUL_LAT(4), .DIV_LAT(8)) dut (
    .clk50MHz (clk50MHz),
    .rst      (rst),
    .go       (go),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .op_q     (op_q),
    .wd       (wd),
    .we       (we),
    .wa       (wa),
    .rea      (rea),
    .reb      (reb),
    .s1       (s1),
    .s2       (s2),
    .alu_start(alu_start),
    .CS_out   (CS_out),
    .Done_out (Done_out),
    .Err_out  (Err_out)
  );

  always #10 clk50MHz = ~clk50MHz;

  function automatic logic [20:0] all_outs();
    return {op_q, wd, we, wa, rea, reb, s1, s2, alu_start, CS_out, Done_out, Err_out};
  endfunction

  task automatic tick();
    @(posedge clk50MHz);
    #1;
  endtask

  // Drops go for one cycle, then raises it with new operands; returns after the start edge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    go = 1'b0;
    tick();
    in1 = a;
    in2 = b;
    op  = o;
    go  = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b1; op = 3'd0; in1 = 4'd0; in2 = 4'd0;
    repeat (3) tick();
    checks++;
    if (all_outs() !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (CS_out !== 4'd0 || we !== 1'b0) begin
        errors++;
        $display("FAIL go_held_idle cyc%0d: CS_out=%0d we=%b expected 0/0", i, CS_out, we);
      end
    end
  endtask

  task automatic test_add();
    start_op(4'd5, 4'd3, 3'b000);
    checks++;
    if ({CS_out, we, wa, wd} !== {4'd1, 1'b1, 2'd0, 4'd5}) begin
      errors++;
      $display("FAIL add_wr_a: CS=%0d we=%b wa=%0d wd=%0d expected 1/1/0/5", CS_out, we, wa, wd);
    end
    tick();
    checks++;
    if ({CS_out, we, wa, wd} !== {4'd2, 1'b1, 2'd1, 4'd3}) begin
      errors++;
      $display("FAIL add_wr_b: CS=%0d we=%b wa=%0d wd=%0d expected 2/1/1/3", CS_out, we, wa, wd);
    end
    tick();
    checks++;
    if ({CS_out, rea, reb, alu_start, we} !== {4'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_rd: CS=%0d rea=%b reb=%b start=%b we=%b expected 3/1/1/0/0",
               CS_out, rea, reb, alu_start, we);
    end
    tick();
    checks++;
    if ({CS_out, alu_start, Done_out} !== {4'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_exec: CS=%0d start=%b done=%b expected 4/1/0", CS_out, alu_start, Done_out);
    end
    tick();
    checks++;
    if ({CS_out, we, wa, s1, wd, alu_start, Done_out} !== {4'd6, 1'b1, 2'd2, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_wb: CS=%0d we=%b wa=%0d s1=%b wd=%0d start=%b done=%b expected 6/1/2/1/0/0/0",
               CS_out, we, wa, s1, wd, alu_start, Done_out);
    end
    tick();
    checks++;
    if ({CS_out, Done_out, s2, we, op_q, Err_out} !== {4'd7, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL add_done: CS=%0d done=%b s2=%b we=%b op_q=%0d err=%b expected 7/1/1/0/0/0",
               CS_out, Done_out, s2, we, op_q, Err_out);
    end
    go = 1'b0;
    repeat (3) tick();
    checks++;
    if ({CS_out, Done_out} !== {4'd7, 1'b1}) begin
      errors++;
      $display("FAIL add_done_hold: CS=%0d done=%b expected 7/1", CS_out, Done_out);
    end
  endtask

  // Runs one operation already started; checks the CS_out trace for latency lat and the pulse counts.
  task automatic check_seq(input string name, input int lat, input logic [2:0] exp_op);
    int n_start, n_rd, n_we, first_done;
    n_start = 0; n_rd = 0; n_we = 0; first_done = 0;
    for (int i = 1; i <= lat + 5; i++) begin
      logic [3:0] exp_cs;
      if (i <= 4)            exp_cs = 4'(i);
      else if (i < lat + 4)  exp_cs = 4'd5;
      else if (i == lat + 4) exp_cs = 4'd6;
      else                   exp_cs = 4'd7;
      checks++;
      if (CS_out !== exp_cs || Err_out !== 1'b0) begin
        errors++;
        $display("FAIL %s_cs cyc%0d: CS=%0d err=%b expected %0d/0", name, i, CS_out, Err_out, exp_cs);
      end
      if (alu_start === 1'b1) n_start++;
      if (rea === 1'b1 && reb === 1'b1) n_rd++;
      if (we === 1'b1) n_we++;
      if (Done_out === 1'b1 && first_done == 0) first_done = i;
      if (i < lat + 5) tick();
    end
    checks++;
    if (n_start != 1 || n_rd != lat + 1 || n_we != 3 || first_done != lat + 5 || op_q !== exp_op) begin
      errors++;
      $display("FAIL %s_counts: start=%0d rd=%0d we=%0d done_at=%0d op_q=%0d expected 1/%0d/3/%0d/%0d",
               name, n_start, n_rd, n_we, first_done, op_q, lat + 1, lat + 5, exp_op);
    end
  endtask

  task automatic test_mul();
    start_op(4'd6, 4'd7, 3'b100);
    check_seq("mul", 4, 3'b100);
  endtask

  task automatic test_pass_a();
    start_op(4'd9, 4'd2, 3'b111);
    check_seq("passa", 1, 3'b111);
  endtask

  task automatic test_back_to_back();
    start_op(4'd9, 4'd2, 3'b101);
    go = 1'b0;
    repeat (5) tick();
    checks++;
    if (CS_out !== 4'd5) begin
      errors++;
      $display("FAIL b2b_in_wait: CS=%0d expected 5", CS_out);
    end
    in1 = 4'd1; in2 = 4'd1; op = 3'b000; go = 1'b1;
    tick();
    checks++;
    if (CS_out !== 4'd5 || op_q !== 3'b101) begin
      errors++;
      $display("FAIL b2b_ignored: CS=%0d op_q=%0d expected 5/5", CS_out, op_q);
    end
    repeat (6) tick();
    checks++;
    if ({CS_out, Done_out, op_q} !== {4'd7, 1'b1, 3'b101}) begin
      errors++;
      $display("FAIL b2b_div_done: CS=%0d done=%b op_q=%0d expected 7/1/5", CS_out, Done_out, op_q);
    end
    start_op(4'd7, 4'd1, 3'b001);
    checks++;
    if ({CS_out, Done_out, s2, wd, op_q} !== {4'd1, 1'b0, 1'b0, 4'd7, 3'b001}) begin
      errors++;
      $display("FAIL b2b_restart: CS=%0d done=%b s2=%b wd=%0d op_q=%0d expected 1/0/0/7/1",
               CS_out, Done_out, s2, wd, op_q);
    end
    repeat (5) tick();
    checks++;
    if ({CS_out, Done_out} !== {4'd7, 1'b1}) begin
      errors++;
      $display("FAIL b2b_sub_done: CS=%0d done=%b expected 7/1", CS_out, Done_out);
    end
  endtask

  task automatic test_rst_wait();
    start_op(4'd4, 4'd2, 3'b101);
    go = 1'b0;
    repeat (6) tick();
    checks++;
    if (CS_out !== 4'd5) begin
      errors++;
      $display("FAIL rstw_pre: CS=%0d expected 5", CS_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (all_outs() !== 21'd0) begin
      errors++;
      $display("FAIL rstw_outputs: got %h expected 0", all_outs());
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (CS_out !== 4'd0 || we !== 1'b0) begin
        errors++;
        $display("FAIL rstw_no_wb cyc%0d: CS=%0d we=%b expected 0/0", i, CS_out, we);
      end
    end
  endtask

  task automatic test_rst_and_start();
    go = 1'b0;
    tick();
    in1 = 4'd3; in2 = 4'd3; op = 3'b010;
    go = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (CS_out !== 4'd0) begin
      errors++;
      $display("FAIL rst_wins: CS=%0d expected 0", CS_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (CS_out !== 4'd0 || op_q !== 3'd0) begin
      errors++;
      $display("FAIL rst_go_held: CS=%0d op_q=%0d expected 0/0", CS_out, op_q);
    end
  endtask

  task automatic test_divz();
    start_op(4'd9, 4'd0, 3'b101);
`ifdef ALU_SEQ_DIVZ_EN
    begin
      int n_start;
      logic [3:0] exp_cs [4] = '{4'd1, 4'd2, 4'd3, 4'd8};
      n_start = 0;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (CS_out !== exp_cs[i]) begin
          errors++;
          $display("FAIL divz_cs cyc%0d: CS=%0d expected %0d", i + 1, CS_out, exp_cs[i]);
        end
        if (alu_start === 1'b1) n_start++;
        if (i < 3) tick();
      end
      repeat (3) begin
        tick();
        if (alu_start === 1'b1) n_start++;
      end
      checks++;
      if ({CS_out, Err_out, Done_out, we} !== {4'd8, 1'b1, 1'b1, 1'b0} || n_start != 0) begin
        errors++;
        $display("FAIL divz_err: CS=%0d err=%b done=%b we=%b starts=%0d expected 8/1/1/0/0",
                 CS_out, Err_out, Done_out, we, n_start);
      end
    end
`else
    check_seq("divz_off", 8, 3'b101);
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_pass_a();
    test_back_to_back();
    test_rst_wait();
    test_rst_and_start();
    test_divz();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
